// File: rtl/txn_dispatcher_if.sv
// Bundles the request, response and store command buses of txn_dispatcher.
// The dispatcher connects through the slave modport; its environment uses master.
interface txn_dispatcher_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_key;
  logic [31:0] req_amount;
  logic        req_kind;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_key;
  logic [31:0] rsp_balance;
  logic [1:0]  rsp_status;

  logic        ram_enable;
  logic        write_enable;
  logic [31:0] key;
  logic [1:0]  signal;
  logic [31:0] transact_value;
  logic        transact_kind;
  logic [31:0] value_addr;
  logic [31:0] updated_value;

  modport slave (
    input  req_valid, req_key, req_amount, req_kind, rsp_ready, value_addr, updated_value,
    output req_ready, rsp_valid, rsp_key, rsp_balance, rsp_status,
    output ram_enable, write_enable, key, signal, transact_value, transact_kind
  );

  modport master (
    output req_valid, req_key, req_amount, req_kind, rsp_ready, value_addr, updated_value,
    input  req_ready, rsp_valid, rsp_key, rsp_balance, rsp_status,
    input  ram_enable, write_enable, key, signal, transact_value, transact_kind
  );
endinterface

// File: rtl/txn_dispatcher.sv
// Queues account transactions and sequences search/check/transact commands to the store.
// Optional macro TXN_STATS_EN adds saturating per-status response counters.
module txn_dispatcher #(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          FIFO_AW        = 2,
  parameter int          STORE_LAT      = 4,
  parameter logic [31:0] NOT_FOUND_ADDR = 32'hFFFF_FFFF
) (
  input  logic              clock,
  input  logic              reset_n,
  txn_dispatcher_if.slave   bus
`ifdef TXN_STATS_EN
  ,
  output logic [31:0]       stat_ok,
  output logic [31:0]       stat_reject,
  output logic [31:0]       stat_notfound
`endif
);

  localparam int CNT_W = (STORE_LAT > 1) ? $clog2(STORE_LAT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(STORE_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] SIG_SEARCH = 2'd0;
  localparam logic [1:0] SIG_IDLE   = 2'd1;
  localparam logic [1:0] SIG_TXN    = 2'd2;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_REJECT    = 2'd1;
  localparam logic [1:0] ST_NOT_FOUND = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEARCH   = 3'd1,
    S_CHECK    = 3'd2,
    S_TRANSACT = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [64:0]        fifo_mem_q [FIFO_DEPTH];
  logic [64:0]        fifo_mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push_s, pop_s, full_s, empty_s;
  logic [31:0]        head_key_s, head_amt_s;
  logic               head_kind_s;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        wk_key_q, wk_key_d, wk_amt_q, wk_amt_d;
  logic               wk_kind_q, wk_kind_d;
  logic [31:0]        bal_q, bal_d, vaddr_q, vaddr_d;
  logic               not_found_s, reject_s;

  logic               ram_enable_q, ram_enable_d;
  logic [31:0]        key_q, key_d;
  logic [1:0]         signal_q, signal_d;
  logic [31:0]        tv_q, tv_d;
  logic               tk_q, tk_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_key_q, rsp_key_d, rsp_balance_q, rsp_balance_d;
  logic [1:0]         rsp_status_q, rsp_status_d;

  assign full_s      = (count_q == DEPTH_C);
  assign empty_s     = (count_q == {(FIFO_AW + 1){1'b0}});
  assign push_s      = bus.req_valid && !full_s;
  assign pop_s       = (state_q == S_IDLE) && !empty_s;
  assign head_key_s  = fifo_mem_q[rptr_q][64:33];
  assign head_amt_s  = fifo_mem_q[rptr_q][32:1];
  assign head_kind_s = fifo_mem_q[rptr_q][0];

  assign not_found_s = (vaddr_q == NOT_FOUND_ADDR);
  assign reject_s    = !wk_kind_q && (wk_amt_q > bal_q);

  assign bus.req_ready      = !full_s;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_key        = rsp_key_q;
  assign bus.rsp_balance    = rsp_balance_q;
  assign bus.rsp_status     = rsp_status_q;
  assign bus.ram_enable     = ram_enable_q;
  assign bus.write_enable   = 1'b0;
  assign bus.key            = key_q;
  assign bus.signal         = signal_q;
  assign bus.transact_value = tv_q;
  assign bus.transact_kind  = tk_q;

  // FIFO pointer, occupancy and storage next-state
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (push_s) begin
      fifo_mem_d[wptr_q] = {bus.req_key, bus.req_amount, bus.req_kind};
      wptr_d             = wptr_q + FIFO_AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + FIFO_AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = empty_s ? S_IDLE : S_SEARCH;
      S_SEARCH:   state_d = (cnt_q == CNT_ZERO) ? S_CHECK : S_SEARCH;
      S_CHECK:    state_d = (not_found_s || reject_s) ? S_RESP : S_TRANSACT;
      S_TRANSACT: state_d = (cnt_q == CNT_ZERO) ? S_RESP : S_TRANSACT;
      S_RESP:     state_d = bus.rsp_ready ? S_IDLE : S_RESP;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs: store command bus, working registers and response
  always_comb begin
    cnt_d         = cnt_q;
    wk_key_d      = wk_key_q;
    wk_amt_d      = wk_amt_q;
    wk_kind_d     = wk_kind_q;
    bal_d         = bal_q;
    vaddr_d       = vaddr_q;
    ram_enable_d  = ram_enable_q;
    key_d         = key_q;
    signal_d      = signal_q;
    tv_d          = tv_q;
    tk_d          = tk_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_key_d     = rsp_key_q;
    rsp_balance_d = rsp_balance_q;
    rsp_status_d  = rsp_status_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          wk_key_d     = head_key_s;
          wk_amt_d     = head_amt_s;
          wk_kind_d    = head_kind_s;
          key_d        = head_key_s;
          signal_d     = SIG_SEARCH;
          tv_d         = 32'd0;
          ram_enable_d = 1'b1;
          cnt_d        = CNT_LOAD;
        end else begin
          ram_enable_d = 1'b0;
        end
      end
      S_SEARCH: begin
        if (cnt_q == CNT_ZERO) begin
          bal_d    = bus.updated_value;
          vaddr_d  = bus.value_addr;
          signal_d = SIG_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHECK: begin
        // Rejected and absent keys finish here without touching the store
        if (not_found_s) begin
          rsp_valid_d   = 1'b1;
          rsp_key_d     = wk_key_q;
          rsp_balance_d = 32'd0;
          rsp_status_d  = ST_NOT_FOUND;
          ram_enable_d  = 1'b0;
        end else if (reject_s) begin
          rsp_valid_d   = 1'b1;
          rsp_key_d     = wk_key_q;
          rsp_balance_d = bal_q;
          rsp_status_d  = ST_REJECT;
          ram_enable_d  = 1'b0;
        end else begin
          signal_d = SIG_TXN;
          tv_d     = wk_amt_q;
          tk_d     = wk_kind_q;
          cnt_d    = CNT_LOAD;
        end
      end
      S_TRANSACT: begin
        if (cnt_q == CNT_ZERO) begin
          rsp_valid_d   = 1'b1;
          rsp_key_d     = wk_key_q;
          rsp_balance_d = bus.updated_value;
          rsp_status_d  = ST_OK;
          signal_d      = SIG_IDLE;
          ram_enable_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        signal_d     = SIG_IDLE;
        ram_enable_d = 1'b0;
        rsp_valid_d  = 1'b0;
      end
    endcase
  end

  // Datapath, FIFO and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 65'd0;
      end
      wptr_q        <= {FIFO_AW{1'b0}};
      rptr_q        <= {FIFO_AW{1'b0}};
      count_q       <= {(FIFO_AW + 1){1'b0}};
      cnt_q         <= CNT_ZERO;
      wk_key_q      <= 32'd0;
      wk_amt_q      <= 32'd0;
      wk_kind_q     <= 1'b0;
      bal_q         <= 32'd0;
      vaddr_q       <= 32'd0;
      ram_enable_q  <= 1'b0;
      key_q         <= 32'd0;
      signal_q      <= SIG_IDLE;
      tv_q          <= 32'd0;
      tk_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_key_q     <= 32'd0;
      rsp_balance_q <= 32'd0;
      rsp_status_q  <= ST_OK;
    end else begin
      fifo_mem_q    <= fifo_mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      cnt_q         <= cnt_d;
      wk_key_q      <= wk_key_d;
      wk_amt_q      <= wk_amt_d;
      wk_kind_q     <= wk_kind_d;
      bal_q         <= bal_d;
      vaddr_q       <= vaddr_d;
      ram_enable_q  <= ram_enable_d;
      key_q         <= key_d;
      signal_q      <= signal_d;
      tv_q          <= tv_d;
      tk_q          <= tk_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_key_q     <= rsp_key_d;
      rsp_balance_q <= rsp_balance_d;
      rsp_status_q  <= rsp_status_d;
    end
  end

`ifdef TXN_STATS_EN
  logic [31:0] stat_ok_q, stat_ok_d, stat_rej_q, stat_rej_d, stat_nf_q, stat_nf_d;
  logic        rsp_hs_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  assign rsp_hs_s      = rsp_valid_q && bus.rsp_ready;
  assign stat_ok       = stat_ok_q;
  assign stat_reject   = stat_rej_q;
  assign stat_notfound = stat_nf_q;

  // Per-status counters advance on the response handshake
  always_comb begin
    stat_ok_d  = sat_inc(stat_ok_q,  rsp_hs_s && (rsp_status_q == ST_OK));
    stat_rej_d = sat_inc(stat_rej_q, rsp_hs_s && (rsp_status_q == ST_REJECT));
    stat_nf_d  = sat_inc(stat_nf_q,  rsp_hs_s && (rsp_status_q == ST_NOT_FOUND));
  end

  // Statistics registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_ok_q  <= 32'd0;
      stat_rej_q <= 32'd0;
      stat_nf_q  <= 32'd0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_rej_q <= stat_rej_d;
      stat_nf_q  <= stat_nf_d;
    end
  end
`endif

endmodule

// File: tb/tb_txn_dispatcher.sv
// Directed bench for txn_dispatcher with a behavioural two-key store model.
module tb_txn_dispatcher;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  txn_dispatcher_if bus();

`ifdef TXN_STATS_EN
  logic [31:0] stat_ok, stat_reject, stat_notfound;
`endif

  txn_dispatcher dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef TXN_STATS_EN
    ,
    .stat_ok       (stat_ok),
    .stat_reject   (stat_reject),
    .stat_notfound (stat_notfound)
`endif
  );

  always #5 clock = ~clock;

  // Store model: keys 249 and 7 exist, every other key is absent
  logic [31:0] bal_249, bal_7, cur_bal;
  logic [1:0]  sig_prev;
  assign cur_bal = (bus.key == 32'd249) ? bal_249 : (bus.key == 32'd7) ? bal_7 : 32'd0;
  assign bus.value_addr = (bus.key == 32'd249) ? 32'h0000_0040 :
                          (bus.key == 32'd7)   ? 32'h0000_0080 : 32'hFFFF_FFFF;
  assign bus.updated_value = (bus.signal == 2'd2) ?
                             (bus.transact_kind ? cur_bal + bus.transact_value : cur_bal - bus.transact_value) :
                             cur_bal;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_prev <= 2'd1;
      bal_249  <= 32'd500;
      bal_7    <= 32'd1000;
    end else begin
      sig_prev <= bus.signal;
      if (sig_prev == 2'd2 && bus.signal != 2'd2) begin
        if (bus.key == 32'd249) bal_249 <= bus.transact_kind ? bal_249 + bus.transact_value : bal_249 - bus.transact_value;
        if (bus.key == 32'd7)   bal_7   <= bus.transact_kind ? bal_7 + bus.transact_value : bal_7 - bus.transact_value;
      end
    end
  end

  // Bus monitor
  int n_search = 0, n_txn = 0, we_err = 0, cyc = 0;
  int starts[$];
  logic [1:0] last_sig = 2'd1;
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.signal == 2'd0) n_search = n_search + 1;
    if (bus.signal == 2'd2) n_txn = n_txn + 1;
    if (bus.write_enable !== 1'b0) we_err = we_err + 1;
    if (bus.signal == 2'd0 && last_sig != 2'd0) starts.push_back(cyc);
    last_sig = bus.signal;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] k, input logic [31:0] a, input logic kd);
    int   n = 0;
    logic ok = 1'b0;
    bus.req_key = k; bus.req_amount = a; bus.req_kind = kd; bus.req_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clock);
      ok = bus.req_ready;
      @(posedge clock);
      n++;
    end
    #1 bus.req_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output logic got);
    int n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clock);
      got = bus.rsp_valid;
      n++;
    end
  endtask

  typedef struct {
    logic [31:0] key;
    logic [31:0] amt;
    logic        kind;
    logic [31:0] exp_bal;
    logic [1:0]  exp_st;
    int          exp_txn;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] bp_key[5], bp_amt[5], bp_bal[5];

  initial begin
    logic got;
    int s0, t0, accepted, cnt, n, q0;
    logic rdy5, rdy6;

    vecs[0] = '{32'd249,   32'd100,       1'b1, 32'd600, 2'd0, 4};
    vecs[1] = '{32'd249,   32'd700,       1'b0, 32'd600, 2'd1, 0};
    vecs[2] = '{32'd249,   32'd600,       1'b0, 32'd0,   2'd0, 4};
    vecs[3] = '{32'd12345, 32'd5,         1'b1, 32'd0,   2'd2, 0};
    vecs[4] = '{32'd7,     32'd250,       1'b0, 32'd750, 2'd0, 4};
    vecs[5] = '{32'd7,     32'd751,       1'b0, 32'd750, 2'd1, 0};
    vecs[6] = '{32'd249,   32'd0,         1'b0, 32'd0,   2'd0, 4};
    vecs[7] = '{32'd7,     32'hFFFF_FFFF, 1'b1, 32'd749, 2'd0, 4};
    bp_key = '{32'd249, 32'd7, 32'd249, 32'd7, 32'd249};
    bp_amt = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    bp_bal = '{32'd1, 32'd751, 32'd4, 32'd755, 32'd9};

    bus.req_valid = 1'b0; bus.req_key = 32'd0; bus.req_amount = 32'd0; bus.req_kind = 1'b0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_signal", {30'd0, bus.signal}, 32'd1);
    chk("rst_ram_enable", {31'd0, bus.ram_enable}, 32'd0);
    chk("rst_key", bus.key, 32'd0);
    chk("rst_rsp_balance", bus.rsp_balance, 32'd0);
    chk("rst_rsp_status", {30'd0, bus.rsp_status}, 32'd0);
    chk("rst_transact_value", bus.transact_value, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      s0 = n_search; t0 = n_txn;
      push_req(vecs[i].key, vecs[i].amt, vecs[i].kind);
      wait_rsp(got);
      chk($sformatf("v%0d_rsp_seen", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_rsp_key", i), bus.rsp_key, vecs[i].key);
      chk($sformatf("v%0d_rsp_balance", i), bus.rsp_balance, vecs[i].exp_bal);
      chk($sformatf("v%0d_rsp_status", i), {30'd0, bus.rsp_status}, {30'd0, vecs[i].exp_st});
      chk($sformatf("v%0d_ram_enable_in_resp", i), {31'd0, bus.ram_enable}, 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk($sformatf("v%0d_rsp_dropped", i), {31'd0, bus.rsp_valid}, 32'd0);
      chk($sformatf("v%0d_search_cycles", i), n_search - s0, 32'd4);
      chk($sformatf("v%0d_transact_cycles", i), n_txn - t0, vecs[i].exp_txn);
      @(posedge clock); #1;
    end

    // Backpressure: five requests fit (one in the engine, four queued)
    bus.rsp_ready = 1'b0;
    accepted = 0; rdy5 = 1'b1; rdy6 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.req_key = (i < 5) ? bp_key[i] : 32'd249;
      bus.req_amount = (i < 5) ? bp_amt[i] : 32'd77;
      bus.req_kind = 1'b1;
      bus.req_valid = 1'b1;
      @(negedge clock);
      if (bus.req_ready) accepted++;
      if (i == 5) rdy5 = bus.req_ready;
      if (i == 6) rdy6 = bus.req_ready;
      @(posedge clock); #1;
    end
    bus.req_valid = 1'b0;
    chk("bp_accepted", accepted, 32'd5);
    chk("bp_ready_6th", {31'd0, rdy5}, 32'd0);
    chk("bp_ready_7th", {31'd0, rdy6}, 32'd0);
    bus.rsp_ready = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 5 && n < 300) begin
      @(negedge clock);
      if (bus.rsp_valid) begin
        chk($sformatf("bp%0d_key", cnt), bus.rsp_key, bp_key[cnt]);
        chk($sformatf("bp%0d_balance", cnt), bus.rsp_balance, bp_bal[cnt]);
        chk($sformatf("bp%0d_status", cnt), {30'd0, bus.rsp_status}, 32'd0);
        cnt++;
      end
      n++;
    end
    chk("bp_drained", cnt, 32'd5);
    repeat (4) @(posedge clock); #1;

    // Back-to-back OK transactions: search commands 2*STORE_LAT+3 apart
    q0 = starts.size();
    push_req(32'd249, 32'd1, 1'b1);
    push_req(32'd7, 32'd1, 1'b1);
    repeat (40) @(posedge clock); #1;
    chk("spacing_searches", starts.size() - q0, 32'd2);
    if (starts.size() >= q0 + 2) chk("spacing_cycles", starts[q0 + 1] - starts[q0], 32'd11);

    // Reset during TRANSACT with one more request queued
    push_req(32'd249, 32'd50, 1'b1);
    push_req(32'd7, 32'd5, 1'b1);
    got = 1'b0; n = 0;
    while (!got && n < 60) begin
      @(negedge clock);
      got = (bus.signal == 2'd2);
      n++;
    end
    chk("rst_mid_reached_transact", {31'd0, got}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_signal", {30'd0, bus.signal}, 32'd1);
    chk("rst_mid_ram_enable", {31'd0, bus.ram_enable}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
`ifdef TXN_STATS_EN
    chk("rst_mid_stat_ok", stat_ok, 32'd0);
    chk("rst_mid_stat_reject", stat_reject, 32'd0);
    chk("rst_mid_stat_notfound", stat_notfound, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    s0 = n_search; t0 = n_txn;
    repeat (30) @(negedge clock);
    chk("rst_queue_discarded", n_search - s0, 32'd0);
    chk("rst_no_reissue", n_txn - t0, 32'd0);
    chk("rst_after_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("write_enable_never_set", we_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
